// File: rtl/phys_reg_file_mp_pkg.sv
// Shared sizing and types for the multi-port physical register file.
// The rename stage, reservation stations and the PRF all agree on these widths.
package prf_pkg;

  parameter int NUM_PREGS = 128;
  parameter int DATA_W    = 32;
  parameter int PREG_W    = $clog2(NUM_PREGS);
  parameter int NUM_RD    = 6;
  parameter int NUM_WR    = 3;
  parameter int NUM_ALLOC = 3;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam preg_t PREG_ZERO = '0;

endpackage

// File: rtl/phys_reg_file_mp_if.sv
// Port bundle between the PRF (slave) and its clients (master).
// Multi-port fields are packed flat, with port i at [i*W +: W].
interface phys_reg_file_mp_if
  import prf_pkg::*;
#(
  parameter int NUM_PREGS = prf_pkg::NUM_PREGS,
  parameter int DATA_W    = prf_pkg::DATA_W,
  parameter int NUM_RD    = prf_pkg::NUM_RD,
  parameter int NUM_WR    = prf_pkg::NUM_WR,
  parameter int NUM_ALLOC = prf_pkg::NUM_ALLOC,
  localparam int PREG_W   = $clog2(NUM_PREGS)
) ();

  logic [NUM_RD-1:0]           rd_en;
  logic [NUM_RD*PREG_W-1:0]    rd_preg;
  logic [NUM_RD*DATA_W-1:0]    rd_data;
  logic [NUM_RD-1:0]           rd_valid;
  logic [NUM_RD*PREG_W-1:0]    chk_preg;
  logic [NUM_RD-1:0]           chk_rdy;
  logic [NUM_WR-1:0]           wb_en;
  logic [NUM_WR*PREG_W-1:0]    wb_preg;
  logic [NUM_WR*DATA_W-1:0]    wb_data;
  logic [NUM_ALLOC-1:0]        alloc_en;
  logic [NUM_ALLOC*PREG_W-1:0] alloc_preg;
  logic                        flush;
  logic [NUM_WR-1:0]           wakeup_valid;
  logic [NUM_WR*PREG_W-1:0]    wakeup_preg;
  logic                        wb_conflict;

  modport master (
    output rd_en, rd_preg, chk_preg, wb_en, wb_preg, wb_data,
           alloc_en, alloc_preg, flush,
    input  rd_data, rd_valid, chk_rdy, wakeup_valid, wakeup_preg, wb_conflict
  );

  modport slave (
    input  rd_en, rd_preg, chk_preg, wb_en, wb_preg, wb_data,
           alloc_en, alloc_preg, flush,
    output rd_data, rd_valid, chk_rdy, wakeup_valid, wakeup_preg, wb_conflict
  );

endinterface

// File: rtl/phys_reg_file_mp_ready_table.sv
// Ready (busy) table: one bit per physical register, with alloc/wb/flush update
// priority and same-cycle writeback forwarding on the query ports.
module prf_ready_table
  import prf_pkg::*;
#(
  parameter int NUM_PREGS = prf_pkg::NUM_PREGS,
  parameter int NUM_RD    = prf_pkg::NUM_RD,
  parameter int NUM_WR    = prf_pkg::NUM_WR,
  parameter int NUM_ALLOC = prf_pkg::NUM_ALLOC,
  localparam int PREG_W   = $clog2(NUM_PREGS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_WR-1:0]           wb_en_i,
  input  logic [NUM_WR*PREG_W-1:0]    wb_preg_i,
  input  logic [NUM_ALLOC-1:0]        alloc_en_i,
  input  logic [NUM_ALLOC*PREG_W-1:0] alloc_preg_i,
  input  logic                        flush_i,
  input  logic [NUM_RD*PREG_W-1:0]    chk_preg_i,
  output logic [NUM_RD-1:0]           chk_rdy_o
);

  logic [NUM_PREGS-1:0] ready_q, ready_d;

  // Later assignments win: wb sets, alloc clears over it, flush overrides both.
  always_comb begin
    ready_d = ready_q;
    for (int k = 0; k < NUM_WR; k++)
      if (wb_en_i[k]) ready_d[wb_preg_i[k*PREG_W +: PREG_W]] = 1'b1;
    for (int j = 0; j < NUM_ALLOC; j++)
      if (alloc_en_i[j]) ready_d[alloc_preg_i[j*PREG_W +: PREG_W]] = 1'b0;
    if (flush_i) ready_d = '1;
    ready_d[0] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ready_q <= '1;
    else         ready_q <= ready_d;
  end

  always_comb begin
    chk_rdy_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      chk_rdy_o[i] = (chk_preg_i[i*PREG_W +: PREG_W] == '0) ||
                     ready_q[chk_preg_i[i*PREG_W +: PREG_W]];
      for (int k = 0; k < NUM_WR; k++)
        if (wb_en_i[k] && (wb_preg_i[k*PREG_W +: PREG_W] == chk_preg_i[i*PREG_W +: PREG_W]))
          chk_rdy_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/phys_reg_file_mp.sv
// Multi-port physical register file: data array, registered reads with
// writeback bypass, per-port wakeup broadcast and writeback conflict flag.
module phys_reg_file_mp
  import prf_pkg::*;
#(
  parameter int NUM_PREGS = prf_pkg::NUM_PREGS,
  parameter int DATA_W    = prf_pkg::DATA_W,
  parameter int NUM_RD    = prf_pkg::NUM_RD,
  parameter int NUM_WR    = prf_pkg::NUM_WR,
  parameter int NUM_ALLOC = prf_pkg::NUM_ALLOC,
  localparam int PREG_W   = $clog2(NUM_PREGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  phys_reg_file_mp_if.slave bus
);

  logic [DATA_W-1:0]        mem_q [NUM_PREGS];
  logic [PREG_W-1:0]        rd_idx [NUM_RD];
  logic [PREG_W-1:0]        wb_idx [NUM_WR];
  logic [DATA_W-1:0]        wb_val [NUM_WR];
  logic [NUM_WR-1:0]        wb_act;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_valid_q;
  logic [NUM_WR*PREG_W-1:0] wake_preg_q, wake_preg_d;
  logic [NUM_WR-1:0]        wake_valid_q;
  logic                     conflict_q, conflict_d;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_idx[i] = bus.rd_preg[i*PREG_W +: PREG_W];
  end

  // A writeback to preg 0 is dropped everywhere, so qualify it once here.
  for (genvar k = 0; k < NUM_WR; k++) begin : g_wb
    assign wb_idx[k] = bus.wb_preg[k*PREG_W +: PREG_W];
    assign wb_val[k] = bus.wb_data[k*DATA_W +: DATA_W];
    assign wb_act[k] = bus.wb_en[k] && (wb_idx[k] != '0);
  end

  always_comb begin
    rd_data_d = rd_data_q;
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.rd_en[i]) begin
        rd_data_d[i*DATA_W +: DATA_W] = mem_q[rd_idx[i]];
        for (int k = 0; k < NUM_WR; k++)
          if (wb_act[k] && (wb_idx[k] == rd_idx[i]))
            rd_data_d[i*DATA_W +: DATA_W] = wb_val[k];
        if (rd_idx[i] == '0) rd_data_d[i*DATA_W +: DATA_W] = '0;
      end
    end
  end

  always_comb begin
    conflict_d  = 1'b0;
    wake_preg_d = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wb_act[k]) wake_preg_d[k*PREG_W +: PREG_W] = wb_idx[k];
      for (int m = k + 1; m < NUM_WR; m++)
        if (wb_act[k] && wb_act[m] && (wb_idx[k] == wb_idx[m])) conflict_d = 1'b1;
    end
  end

  // Ascending port order makes the highest-index writer win on a collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PREGS; p++) mem_q[p] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++)
        if (wb_act[k]) mem_q[wb_idx[k]] <= wb_val[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q    <= '0;
      rd_valid_q   <= '0;
      wake_valid_q <= '0;
      wake_preg_q  <= '0;
      conflict_q   <= 1'b0;
    end else begin
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= bus.rd_en;
      wake_valid_q <= wb_act;
      wake_preg_q  <= wake_preg_d;
      conflict_q   <= conflict_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++)
      assert (int'(rd_idx[i]) < NUM_PREGS &&
              int'(bus.chk_preg[i*PREG_W +: PREG_W]) < NUM_PREGS);
    for (int k = 0; k < NUM_WR; k++)
      assert (int'(wb_idx[k]) < NUM_PREGS);
    for (int j = 0; j < NUM_ALLOC; j++)
      assert (int'(bus.alloc_preg[j*PREG_W +: PREG_W]) < NUM_PREGS);
  end

  prf_ready_table #(
    .NUM_PREGS (NUM_PREGS),
    .NUM_RD    (NUM_RD),
    .NUM_WR    (NUM_WR),
    .NUM_ALLOC (NUM_ALLOC)
  ) u_ready_table (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .wb_en_i      (wb_act),
    .wb_preg_i    (bus.wb_preg),
    .alloc_en_i   (bus.alloc_en),
    .alloc_preg_i (bus.alloc_preg),
    .flush_i      (bus.flush),
    .chk_preg_i   (bus.chk_preg),
    .chk_rdy_o    (bus.chk_rdy)
  );

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.wakeup_valid = wake_valid_q;
  assign bus.wakeup_preg  = wake_preg_q;
  assign bus.wb_conflict  = conflict_q;

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Directed bench for phys_reg_file_mp: reset, alloc/wb, bypass, conflict,
// preg 0, alloc-vs-wb priority and flush recovery.
module tb_phys_reg_file_mp;
  import prf_pkg::*;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  phys_reg_file_mp_if bus ();

  phys_reg_file_mp dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus();
    bus.rd_en      = '0;
    bus.rd_preg    = '0;
    bus.chk_preg   = '0;
    bus.wb_en      = '0;
    bus.wb_preg    = '0;
    bus.wb_data    = '0;
    bus.alloc_en   = '0;
    bus.alloc_preg = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic setRd(input int i, input preg_t p);
    bus.rd_en[i] = 1'b1;
    bus.rd_preg[i*PREG_W +: PREG_W] = p;
  endtask

  task automatic setChk(input int i, input preg_t p);
    bus.chk_preg[i*PREG_W +: PREG_W] = p;
  endtask

  task automatic setWb(input int k, input preg_t p, input data_t d);
    bus.wb_en[k] = 1'b1;
    bus.wb_preg[k*PREG_W +: PREG_W] = p;
    bus.wb_data[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic setAlloc(input int j, input preg_t p);
    bus.alloc_en[j] = 1'b1;
    bus.alloc_preg[j*PREG_W +: PREG_W] = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rdData(input int i);
    return 32'(bus.rd_data[i*DATA_W +: DATA_W]);
  endfunction

  function automatic logic [31:0] wakePreg(input int k);
    return 32'(bus.wakeup_preg[k*PREG_W +: PREG_W]);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    applyStimulus();
    reset_n = 1'b0;
    tick();
    tick();

    // Reset state
    for (int i = 0; i < NUM_RD; i++) setChk(i, preg_t'(i + 1));
    #1;
    checkOutput("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    checkOutput("rst_rd_data0", rdData(0), 32'h0);
    checkOutput("rst_wake_valid", 32'(bus.wakeup_valid), 32'h0);
    checkOutput("rst_wake_preg", 32'(bus.wakeup_preg), 32'h0);
    checkOutput("rst_conflict", 32'(bus.wb_conflict), 32'h0);
    checkOutput("rst_chk_rdy", 32'(bus.chk_rdy), 32'h3F);
    reset_n = 1'b1;
    tick();

    // Read after reset: everything is zero
    applyStimulus();
    setRd(0, 1); setRd(1, 2); setRd(2, 3); setRd(3, 64); setRd(4, 100); setRd(5, 127);
    tick();
    checkOutput("post_rst_rd_valid", 32'(bus.rd_valid), 32'h3F);
    for (int i = 0; i < NUM_RD; i++)
      checkOutput($sformatf("post_rst_rd_data%0d", i), rdData(i), 32'h0);
    checkOutput("post_rst_wake_valid", 32'(bus.wakeup_valid), 32'h0);

    // Reset mid-read drops rd_valid without waiting for a clock
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_rd_valid", 32'(bus.rd_valid), 32'h0);
    applyStimulus();
    #2;
    reset_n = 1'b1;
    tick();

    // Alloc preg 5; same-cycle query still sees it ready
    applyStimulus();
    setAlloc(0, 5);
    setChk(0, 5);
    #1;
    checkOutput("alloc_same_cycle_chk", 32'(bus.chk_rdy[0]), 32'h1);
    tick();
    applyStimulus();
    setChk(0, 5);
    #1;
    checkOutput("alloc_next_cycle_chk", 32'(bus.chk_rdy[0]), 32'h0);
    tick();
    tick();
    setWb(0, 5, 32'hDEADBEEF);
    #1;
    checkOutput("wb_forward_chk", 32'(bus.chk_rdy[0]), 32'h1);
    tick();
    applyStimulus();
    setChk(0, 5);
    setRd(0, 5);
    checkOutput("wb5_wake_valid", 32'(bus.wakeup_valid), 32'h1);
    checkOutput("wb5_wake_preg", wakePreg(0), 32'd5);
    #1;
    checkOutput("wb5_ready_reg", 32'(bus.chk_rdy[0]), 32'h1);
    tick();
    checkOutput("rd5_data", rdData(0), 32'hDEADBEEF);
    checkOutput("rd5_valid", 32'(bus.rd_valid), 32'h1);
    checkOutput("rd5_wake_cleared", 32'(bus.wakeup_valid), 32'h0);

    // Bypass: write and read preg 9 in the same cycle
    applyStimulus();
    setWb(1, 9, 32'h1234);
    setRd(2, 9);
    tick();
    checkOutput("bypass_rd_data2", rdData(2), 32'h1234);
    checkOutput("bypass_hold_rd_data0", rdData(0), 32'hDEADBEEF);
    checkOutput("bypass_wake_valid", 32'(bus.wakeup_valid), 32'h2);
    checkOutput("bypass_wake_preg1", wakePreg(1), 32'd9);

    // Conflict: ports 0 and 2 both write preg 7, port 2 wins
    applyStimulus();
    setWb(0, 7, 32'hA);
    setWb(2, 7, 32'hB);
    tick();
    applyStimulus();
    setRd(0, 7);
    checkOutput("conflict_flag", 32'(bus.wb_conflict), 32'h1);
    checkOutput("conflict_wake_valid", 32'(bus.wakeup_valid), 32'h5);
    checkOutput("conflict_wake_preg0", wakePreg(0), 32'd7);
    checkOutput("conflict_wake_preg2", wakePreg(2), 32'd7);
    tick();
    checkOutput("conflict_rd_data", rdData(0), 32'hB);
    checkOutput("conflict_flag_clear", 32'(bus.wb_conflict), 32'h0);

    // Preg 0: writes ignored, no wakeup, no conflict, reads zero even with bypass
    applyStimulus();
    setWb(0, 0, 32'hFFFF);
    setWb(1, 0, 32'hFFFF);
    setRd(1, 0);
    tick();
    applyStimulus();
    setRd(1, 0);
    checkOutput("p0_bypass_rd_data", rdData(1), 32'h0);
    checkOutput("p0_wake_valid", 32'(bus.wakeup_valid), 32'h0);
    checkOutput("p0_conflict", 32'(bus.wb_conflict), 32'h0);
    tick();
    checkOutput("p0_rd_data", rdData(1), 32'h0);

    // Alloc beats writeback on the ready bit; data still lands
    applyStimulus();
    setAlloc(1, 20);
    setWb(2, 20, 32'h55AA);
    setChk(3, 20);
    #1;
    checkOutput("prio_same_cycle_chk", 32'(bus.chk_rdy[3]), 32'h1);
    tick();
    applyStimulus();
    setChk(3, 20);
    setRd(3, 20);
    #1;
    checkOutput("prio_ready_cleared", 32'(bus.chk_rdy[3]), 32'h0);
    tick();
    checkOutput("prio_rd_data", rdData(3), 32'h55AA);

    // Flush restores the ready table, overriding a same-cycle alloc
    applyStimulus();
    setAlloc(0, 30);
    setAlloc(2, 31);
    tick();
    applyStimulus();
    setChk(0, 30);
    setChk(1, 31);
    #1;
    checkOutput("pre_flush_chk", 32'(bus.chk_rdy[1:0]), 32'h0);
    bus.flush = 1'b1;
    setAlloc(0, 40);
    setWb(0, 41, 32'h77);
    tick();
    applyStimulus();
    setChk(0, 30);
    setChk(1, 31);
    setChk(2, 40);
    setChk(3, 20);
    setRd(0, 41);
    checkOutput("flush_wake_valid", 32'(bus.wakeup_valid), 32'h1);
    checkOutput("flush_wake_preg", wakePreg(0), 32'd41);
    #1;
    checkOutput("flush_chk_rdy", 32'(bus.chk_rdy[3:0]), 32'hF);
    tick();
    checkOutput("flush_rd_data", rdData(0), 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
